// File: rtl/ins_rom_fetch.sv
// ins_rom_fetch: instruction fetch controller between the core's instruction
// port and a byte-wide instruction ROM bus. A word request is served either
// from a one-word hit buffer (one-cycle latency) or by reading four bytes from
// the ROM and assembling them little-endian into a 32-bit instruction.
//
// Ports:
//   clk, nrst      clock; synchronous active-low reset
//   exIns_ren      core fetch request (single-cycle pulse is enough)
//   exIns_addr     core byte address, bits [1:0] ignored
//   flush          invalidate the hit buffer
//   exIns_valid    one-cycle pulse, ins_data valid for the latest request
//   ins_data       assembled instruction word, held until next exIns_valid
//   rom_req        byte read request, held until rom_ack
//   rom_addr       ROM byte address, stable while rom_req is high
//   rom_ack        byte accepted, rom_rdata valid in the same cycle
//   rom_rdata      ROM byte
module ins_rom_fetch #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              exIns_ren,
  input  logic [ADDR_W-1:0] exIns_addr,
  input  logic              flush,
  output logic              exIns_valid,
  output logic [31:0]       ins_data,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [7:0]        rom_rdata
);

  localparam int unsigned TAG_W = ADDR_W - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [TAG_W-1:0]  base_q, base_d;
  logic [1:0]        k_q, k_d;
  logic [23:0]       word_q, word_d;
  logic              valid_q, valid_d;
  logic [31:0]       ins_data_q, ins_data_d;
  logic              rom_req_q, rom_req_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [31:0]       buf_data_q, buf_data_d;
  logic [TAG_W-1:0]  buf_tag_q, buf_tag_d;
  logic              buf_valid_q, buf_valid_d;
  logic              pend_valid_q, pend_valid_d;
  logic [TAG_W-1:0]  pend_tag_q, pend_tag_d;
  logic              flushed_q, flushed_d;

  logic [TAG_W-1:0]  req_tag;
  logic              hit;
  logic              redirect;
  logic [TAG_W-1:0]  next_tag;
  logic [1:0]        k_inc;

  assign exIns_valid = valid_q;
  assign ins_data    = ins_data_q;
  assign rom_req     = rom_req_q;
  assign rom_addr    = rom_addr_q;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    k_d          = k_q;
    word_d       = word_q;
    valid_d      = 1'b0;
    ins_data_d   = ins_data_q;
    rom_req_d    = rom_req_q;
    rom_addr_d   = rom_addr_q;
    buf_data_d   = buf_data_q;
    buf_tag_d    = buf_tag_q;
    buf_valid_d  = buf_valid_q;
    pend_valid_d = pend_valid_q;
    pend_tag_d   = pend_tag_q;
    flushed_d    = flushed_q;
    req_tag      = exIns_addr[ADDR_W-1:2];
    hit          = buf_valid_q && (req_tag == buf_tag_q) && !flush;
    redirect     = 1'b0;
    next_tag     = pend_tag_q;
    k_inc        = k_q + 2'd1;

    if (flush) begin
      buf_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (exIns_ren) begin
          if (hit) begin
            state_d    = RESP;
            valid_d    = 1'b1;
            ins_data_d = buf_data_q;
          end else begin
            state_d      = FETCH;
            base_d       = req_tag;
            k_d          = '0;
            pend_valid_d = 1'b0;
            flushed_d    = 1'b0;
            rom_req_d    = 1'b1;
            rom_addr_d   = {req_tag, 2'b00};
          end
        end
      end

      FETCH: begin
        if (flush) begin
          flushed_d = 1'b1;
        end
        redirect = exIns_ren && (req_tag != base_q);
        if (redirect) begin
          pend_valid_d = 1'b1;
          pend_tag_d   = req_tag;
          next_tag     = req_tag;
        end
        if (rom_ack) begin
          if (redirect || pend_valid_q) begin
            // A redirect seen in the ack cycle restarts immediately; the
            // in-flight byte has just completed, so nothing is dropped.
            base_d       = next_tag;
            k_d          = '0;
            pend_valid_d = 1'b0;
            rom_addr_d   = {next_tag, 2'b00};
          end else if (k_q == 2'd3) begin
            state_d    = RESP;
            valid_d    = 1'b1;
            ins_data_d = {rom_rdata, word_q};
            rom_req_d  = 1'b0;
            if (!flushed_q && !flush) begin
              buf_data_d  = {rom_rdata, word_q};
              buf_tag_d   = base_q;
              buf_valid_d = 1'b1;
            end
          end else begin
            case (k_q)
              2'd0:    word_d[7:0]   = rom_rdata;
              2'd1:    word_d[15:8]  = rom_rdata;
              default: word_d[23:16] = rom_rdata;
            endcase
            k_d        = k_inc;
            rom_addr_d = {base_q, k_inc};
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= IDLE;
      base_q       <= '0;
      k_q          <= '0;
      word_q       <= '0;
      valid_q      <= 1'b0;
      ins_data_q   <= '0;
      rom_req_q    <= 1'b0;
      rom_addr_q   <= '0;
      buf_data_q   <= '0;
      buf_tag_q    <= '0;
      buf_valid_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_tag_q   <= '0;
      flushed_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      k_q          <= k_d;
      word_q       <= word_d;
      valid_q      <= valid_d;
      ins_data_q   <= ins_data_d;
      rom_req_q    <= rom_req_d;
      rom_addr_q   <= rom_addr_d;
      buf_data_q   <= buf_data_d;
      buf_tag_q    <= buf_tag_d;
      buf_valid_q  <= buf_valid_d;
      pend_valid_q <= pend_valid_d;
      pend_tag_q   <= pend_tag_d;
      flushed_q    <= flushed_d;
    end
  end

endmodule

// File: doc/ins_rom_fetch.md
# ins_rom_fetch

Instruction-side fetch controller feeding the core's external instruction port (exIns_ren/exIns_addr in, exIns_valid/instruction word out). It serves each word request from a byte-wide instruction ROM bus. It assembles four little-endian bytes into a 32-bit word and keeps a one-word hit buffer, so straight-line re-fetches and tight loops return in one cycle. It sits directly upstream of the core's instruction fetch stage.

## Interface
- ADDR_W, 32, width of core and ROM address buses
- clk  in  1  clock; all state updates on rising edge
- nrst  in  1  reset; synchronous, active-low
- exIns_ren  in  1  core fetch request, one-cycle pulse sufficient
- exIns_addr  in  ADDR_W  core byte address; bits [1:0] ignored (forced 0)
- flush  in  1  invalidate hit buffer (fence.i / self-modifying code)
- exIns_valid  out  1  one-cycle pulse: ins_data valid for the most recently accepted request
- ins_data  out  32  assembled instruction word, held until the next exIns_valid
- rom_req  out  1  byte read request, held until rom_ack
- rom_addr  out  ADDR_W  byte address, stable while rom_req is high
- rom_ack  in  1  byte accepted; rom_rdata valid in the same cycle
- rom_rdata  in  8  ROM byte

## Operation
- State machine: IDLE, FETCH, RESP.
- Hit buffer: buf_data[31:0], buf_tag[ADDR_W-1:2], buf_valid.
- Acceptance: exIns_ren is accepted in IDLE or RESP. In FETCH it is a redirect (see below).
- Hit: accepted, buf_valid=1, addr[ADDR_W-1:2]==buf_tag, flush=0.
  - ins_data=buf_data, exIns_valid=1 next cycle.
  - State ends in IDLE (RESP is used for the pulse).
- Miss: otherwise.
  - Latch base={addr[ADDR_W-1:2],2'b00}, byte index k=0, go to FETCH.
- FETCH:
  - rom_req=1, rom_addr=base+k.
  - On rom_ack: word[8k+7:8k]=rom_rdata, k=k+1. rom_req stays high and rom_addr advances the next cycle.
  - After the ack with k==3: go to RESP, load ins_data, buf_data=word, buf_tag=base[ADDR_W-1:2], buf_valid=1 (unless a flush occurred during the fetch).
- RESP: exIns_valid=1 for exactly one cycle, then IDLE unless a new request is accepted in the same cycle.
- Redirect: exIns_ren in FETCH with a different word address.
  - Record it in a pending register; the latest redirect wins.
  - The in-flight byte handshake completes; rom_req is never dropped before ack.
  - After that ack: discard the partial word, set base to the pending address, k=0, continue FETCH.
  - No exIns_valid and no buffer update for the abandoned word.
- exIns_ren in FETCH with the same word address as base: ignored.
- flush:
  - Clears buf_valid that cycle.
  - flush together with a hit-eligible request: flush wins, treated as a miss.
  - flush during FETCH: the current word is still returned but not written into the buffer.
- rom_ack while rom_req=0: ignored.
- Address arithmetic: base+k is modulo 2^ADDR_W. Only bits [1:0] change, because base is word-aligned.

## Timing
- Reset (nrst=0 at an edge): state=IDLE, exIns_valid=0, ins_data=0, rom_req=0, rom_addr=0, buf_valid=0, pending cleared.
- Reset mid-fetch: rom_req=0 after that edge; later acks are ignored.
- All outputs are registered.
- Hit latency: exIns_ren at cycle t gives exIns_valid at t+1.
- Miss latency: rom_req rises at t+1. With w_i wait cycles before the ack of byte i, exIns_valid is at t+5+Σw_i.
- Zero-wait ROM: valid at t+5; rom_req is high for exactly 4 consecutive cycles.
- Back-to-back: a request accepted in the RESP cycle starts the next fetch (or hit) with no bubble.

## Test plan
- Reset: hold nrst=0 for 3 cycles with rom_ack=1 and exIns_ren=1 -> all outputs 0. The first request after release is a miss.
- Zero-wait miss: ren at addr 0x103, ROM bytes 0x13,0x05,0x10,0x00 at 0x100..0x103 -> rom_addr 0x100..0x103 on consecutive cycles, ins_data=0x00100513, exIns_valid at t+5.
- Hit: repeat ren at 0x100 after the above -> valid at t+1, ins_data=0x00100513, rom_req stays 0.
- Wait states: 2 idle cycles before each ack, miss at 0x200 -> valid at t+13, rom_addr stable while waiting.
- Redirect: miss at 0x300, redirect ren at 0x400 during byte 1 -> byte 1 completes, fetch restarts at 0x400. Only one exIns_valid, carrying 0x400's word; a later ren at 0x300 misses.
- Flush: flush together with ren at a buffered address -> treated as a miss, full fetch. Flush during a fetch -> word returned, and the next ren to the same address misses.
